tile_scrambler: RTL and testbench
=================================

# tile_scrambler

Move generator for the 3x3 sliding-tile puzzle. After a `start` it produces a pseudo-random sequence of `num_moves` legal blank-space moves on the puzzle's `direction` encoding, and presents each move over a valid/ready handshake. It tracks the blank position itself, so it never emits an out-of-bounds move and never immediately undoes the previous move. It sits upstream of the puzzle core, which consumes one direction per accepted handshake, and is used to scramble a freshly reset board.

## Interface
- `NUM_MOVES_W`, default 8: width of the move-count input.
- `SEED`, default 16'hACE1: LFSR reset value; also used when a zero seed is loaded.
- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high; clock `clk`.
- `start`  in  1  single-cycle request to begin a scramble; sampled only in IDLE.
- `num_moves`  in  NUM_MOVES_W  number of moves, sampled with `start`.
- `seed_load`  in  1  load `seed` into the LFSR; honoured only in IDLE.
- `seed`  in  16  LFSR seed value.
- `move_val`  out  1  `direction` holds a valid move.
- `move_rdy`  in  1  consumer accepts the move; a handshake occurs when `move_val & move_rdy`.
- `direction`  out  2  move encoding: LEFT=00, RIGHT=01, UP=10, DOWN=11. The direction is the movement of the blank.
- `busy`  out  1  high in GEN and OFFER.
- `done`  out  1  one-cycle pulse when a scramble completes.
- `space_row`  out  2  tracked blank row, 0..2.
- `space_col`  out  2  tracked blank column, 0..2.

## Operation
- **Reset values:**
  - state = IDLE, LFSR = SEED, `space_row`/`space_col` = 2/2.
  - No previous move recorded; try counter = 0; remaining count = 0.
  - `move_val` = 0, `direction` = 00, `busy` = 0, `done` = 0.
- **LFSR:** 16-bit Galois, mask 16'hB400. Each step is `lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 0)`.
- **IDLE:**
  - `seed_load` loads `seed`; if `seed` is 0, loads SEED instead.
  - `start` with `num_moves == 0`: pulse `done` next cycle and stay in IDLE.
  - `start` with a nonzero count: latch the count, clear the previous-move record, clear the try counter, go to GEN.
  - If `seed_load` and `start` arrive together, the seed is loaded first and generation uses the new seed.
- **GEN**, one candidate per cycle; the LFSR steps every GEN cycle:
  - The candidate is `lfsr[1:0]`.
  - The candidate is legal when it stays in bounds and is not the inverse of the previous move. Bounds: LEFT needs col > 0, RIGHT needs col < 2, UP needs row > 0, DOWN needs row < 2. Inverse pairs are LEFT/RIGHT and UP/DOWN.
  - If legal: latch it into `direction`, go to OFFER.
  - If illegal and the try counter is below 3: increment the try counter and stay in GEN.
  - If illegal and the try counter equals 3: fallback. Latch the first legal direction in the order LEFT, RIGHT, UP, DOWN, then go to OFFER. At least one legal move always exists.
- **OFFER:**
  - `move_val` = 1. `direction` is held stable until the handshake.
  - On the handshake:
    - Update `space_row`/`space_col` per the move.
    - Record the previous move, decrement the remaining count, clear the try counter.
    - If the remaining count was 1: go to IDLE and pulse `done`. Otherwise go to GEN.
- `start` and `seed_load` are ignored outside IDLE.
- The blank position persists across scrambles; only `reset` returns it to (2,2).
- **Reset mid-operation:** abandons the sequence. All outputs take their reset values on the following edge; no `done` is pulsed.

## Timing
- `start` sampled at edge k: GEN at k+1. `move_val` rises at k+2 at the earliest and at k+5 at the latest (bounded by the try counter).
- After a handshake at edge m: the next `move_val` rises at m+2 at the earliest.
- `done` is asserted in the cycle after the final handshake, together with `busy` = 0, for exactly one cycle.
- `space_row`/`space_col` update on the handshake edge and are registered outputs.
- `move_val` never deasserts without a handshake, except on reset.

## Test plan
- **Reset:** after reset, expect `move_val`=0, `busy`=0, `done`=0, blank at (2,2). Then `start` with `num_moves`=1, `move_rdy`=1. The single move is LEFT or UP, `done` pulses once, and the blank ends at (2,1) or (1,2).
- **Zero count:** `start` with `num_moves`=0. `done` is high exactly 1 cycle later, `move_val` never rises, `busy` stays 0.
- **Backpressure:** `move_rdy`=0 for 10 cycles while `move_val`=1. `direction` and the blank position are unchanged throughout. The handshake in cycle 11 advances the blank by exactly one cell.
- **Legality scoreboard:** `num_moves`=255 with `move_rdy` randomly toggled. Every emitted move is in bounds and is never the inverse of the previous one. The blank outputs match a reference model after every handshake. Exactly 255 handshakes occur, then one `done`.
- **Seed reproducibility:** after reset, load seed 16'h1234 and scramble 20 moves; repeat the reset and load. Both direction sequences are identical. Loading seed 0 yields the same sequence as the reset default SEED.
- **Reset mid-run:** assert `reset` after the 3rd handshake of a 10-move scramble. The next cycle shows `move_val`=0, `busy`=0, blank (2,2), and no `done`. A subsequent `start` works normally.

Source files
------------

// File: rtl/tile_scrambler.sv
// tile_scrambler
//   Move generator for the 3x3 sliding-tile puzzle. After a start it
//   produces num_moves pseudo-random legal moves of the blank. Each move is
//   offered over a valid/ready handshake. The blank position is tracked
//   internally, so a move never leaves the board and never undoes the
//   previous move.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   start, num_moves    begin a scramble of num_moves moves (IDLE only)
//   seed_load, seed     reload the LFSR (IDLE only; zero seed -> SEED)
//   move_val, move_rdy  move handshake toward the puzzle core
//   direction           LEFT=00 RIGHT=01 UP=10 DOWN=11 (movement of blank)
//   busy                high while generating or offering
//   done                one-cycle pulse after the final handshake
//   space_row/col       tracked blank position, 0..2
module tile_scrambler #(
    parameter int unsigned NUM_MOVES_W = 8,
    parameter logic [15:0] SEED        = 16'hACE1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [NUM_MOVES_W-1:0] num_moves,
    input  logic                   seed_load,
    input  logic [15:0]            seed,
    output logic                   move_val,
    input  logic                   move_rdy,
    output logic [1:0]             direction,
    output logic                   busy,
    output logic                   done,
    output logic [1:0]             space_row,
    output logic [1:0]             space_col
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GEN   = 2'd1;
    localparam logic [1:0] OFFER = 2'd2;

    localparam logic [1:0] DIR_LEFT  = 2'b00;
    localparam logic [1:0] DIR_RIGHT = 2'b01;
    localparam logic [1:0] DIR_UP    = 2'b10;
    localparam logic [1:0] DIR_DOWN  = 2'b11;

    logic [1:0]             state;
    logic [15:0]            lfsr;
    logic [15:0]            lfsr_next;
    logic                   prev_valid;
    logic [1:0]             prev_dir;
    logic [1:0]             tries;
    logic [NUM_MOVES_W-1:0] remaining;
    logic [1:0]             candidate;
    logic                   candidate_ok;
    logic [1:0]             fallback;

    // Inverse pairs differ only in bit 0 (LEFT/RIGHT, UP/DOWN).
    function automatic logic move_ok(input logic [1:0] d,
                                     input logic [1:0] row,
                                     input logic [1:0] col,
                                     input logic       pv,
                                     input logic [1:0] pd);
        logic in_bounds;
        case (d)
            DIR_LEFT:  in_bounds = (col != 2'd0);
            DIR_RIGHT: in_bounds = (col < 2'd2);
            DIR_UP:    in_bounds = (row != 2'd0);
            default:   in_bounds = (row < 2'd2);
        endcase
        return in_bounds && !(pv && (d == (pd ^ 2'b01)));
    endfunction

    assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign candidate = lfsr[1:0];

    always_comb begin
        candidate_ok = move_ok(candidate, space_row, space_col, prev_valid, prev_dir);
        // Fixed-priority search used once the random tries are exhausted.
        fallback = DIR_DOWN;
        if (move_ok(DIR_LEFT, space_row, space_col, prev_valid, prev_dir))
            fallback = DIR_LEFT;
        else if (move_ok(DIR_RIGHT, space_row, space_col, prev_valid, prev_dir))
            fallback = DIR_RIGHT;
        else if (move_ok(DIR_UP, space_row, space_col, prev_valid, prev_dir))
            fallback = DIR_UP;
    end

    assign move_val = (state == OFFER);
    assign busy     = (state == GEN) || (state == OFFER);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            lfsr       <= SEED;
            space_row  <= 2'd2;
            space_col  <= 2'd2;
            prev_valid <= 1'b0;
            prev_dir   <= DIR_LEFT;
            tries      <= '0;
            remaining  <= '0;
            direction  <= DIR_LEFT;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (seed_load)
                        lfsr <= (seed == 16'h0000) ? SEED : seed;
                    if (start) begin
                        if (num_moves == '0) begin
                            done <= 1'b1;
                        end else begin
                            remaining  <= num_moves;
                            prev_valid <= 1'b0;
                            tries      <= '0;
                            state      <= GEN;
                        end
                    end
                end
                GEN: begin
                    lfsr <= lfsr_next;
                    if (candidate_ok) begin
                        direction <= candidate;
                        state     <= OFFER;
                    end else if (tries != 2'd3) begin
                        tries <= tries + 2'd1;
                    end else begin
                        direction <= fallback;
                        state     <= OFFER;
                    end
                end
                OFFER: begin
                    if (move_rdy) begin
                        case (direction)
                            DIR_LEFT:  space_col <= space_col - 2'd1;
                            DIR_RIGHT: space_col <= space_col + 2'd1;
                            DIR_UP:    space_row <= space_row - 2'd1;
                            default:   space_row <= space_row + 2'd1;
                        endcase
                        prev_valid <= 1'b1;
                        prev_dir   <= direction;
                        remaining  <= remaining - NUM_MOVES_W'(1);
                        tries      <= '0;
                        if (remaining == NUM_MOVES_W'(1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            state <= GEN;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tile_scrambler.sv
// tb_tile_scrambler
//   Directed bench for tile_scrambler. An independent model of the move
//   generator predicts each direction and its latency; predictions are
//   queued when a scramble step is launched and compared when the DUT
//   offers the move. Blank position, busy and done are checked per step.
module tb_tile_scrambler;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] num_moves;
    logic       seed_load;
    logic [15:0] seed;
    logic       move_val;
    logic       move_rdy;
    logic [1:0] direction;
    logic       busy;
    logic       done;
    logic [1:0] space_row;
    logic [1:0] space_col;

    tile_scrambler #(.NUM_MOVES_W(8), .SEED(SEED)) dut (
        .clk(clk), .reset(reset), .start(start), .num_moves(num_moves),
        .seed_load(seed_load), .seed(seed), .move_val(move_val),
        .move_rdy(move_rdy), .direction(direction), .busy(busy), .done(done),
        .space_row(space_row), .space_col(space_col)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    // reference model state
    logic [15:0] m_lfsr;
    logic [1:0]  m_row, m_col, m_prev;
    logic        m_pv;

    logic [1:0] q_dir[$];
    int         q_lat[$];
    logic [1:0] seq_obs[$];
    logic [1:0] seq_a[$];
    logic [1:0] seq_b[$];
    logic [1:0] seq_def[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic m_legal(input logic [1:0] d);
        logic ib;
        case (d)
            2'b00:   ib = (m_col > 2'd0);
            2'b01:   ib = (m_col < 2'd2);
            2'b10:   ib = (m_row > 2'd0);
            default: ib = (m_row < 2'd2);
        endcase
        if (m_pv && ((d == 2'b00 && m_prev == 2'b01) || (d == 2'b01 && m_prev == 2'b00) ||
                     (d == 2'b10 && m_prev == 2'b11) || (d == 2'b11 && m_prev == 2'b10)))
            return 1'b0;
        return ib;
    endfunction

    // Predict the next move and how many GEN cycles it takes.
    task automatic model_gen(output logic [1:0] d, output int cyc);
        logic [1:0] c;
        for (int t = 0; t < 4; t++) begin
            c = m_lfsr[1:0];
            m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
            if (m_legal(c)) begin
                d = c;
                cyc = t + 1;
                return;
            end
        end
        cyc = 4;
        d = 2'b11;
        for (int k = 3; k >= 0; k--)
            if (m_legal(2'(k))) d = 2'(k);
    endtask

    task automatic model_apply(input logic [1:0] d);
        case (d)
            2'b00:   m_col = m_col - 2'd1;
            2'b01:   m_col = m_col + 2'd1;
            2'b10:   m_row = m_row - 2'd1;
            default: m_row = m_row + 2'd1;
        endcase
        m_pv = 1'b1;
        m_prev = d;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_lfsr = SEED; m_row = 2'd2; m_col = 2'd2; m_pv = 1'b0; m_prev = 2'b00;
    endtask

    task automatic load_seed(input logic [15:0] v);
        @(posedge clk); #1;
        seed_load = 1'b1; seed = v;
        @(posedge clk); #1;
        seed_load = 1'b0;
        m_lfsr = (v == 16'h0000) ? SEED : v;
    endtask

    // stall < 0: random ready (50%); otherwise stall exactly that many cycles.
    // stop_after > 0: return right after that handshake.
    task automatic run(input int n, input int stall, input int stop_after,
                       input logic sl, input logic [15:0] sv);
        logic [1:0] d, exp_d, hold;
        int cyc, lat, stalls, hs;
        logic rdy;
        seq_obs.delete();
        hs = 0;
        @(posedge clk); #1;
        start = 1'b1; num_moves = 8'(n);
        seed_load = sl; seed = sv;
        if (sl) m_lfsr = (sv == 16'h0000) ? SEED : sv;
        m_pv = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; seed_load = 1'b0;
        if (n == 0) begin
            chk("zero_done", 32'(done), 32'd1);
            chk("zero_busy", 32'(busy), 32'd0);
            chk("zero_val", 32'(move_val), 32'd0);
            @(posedge clk); #1;
            chk("zero_done_once", 32'(done), 32'd0);
            chk("zero_val2", 32'(move_val), 32'd0);
            chk("zero_busy2", 32'(busy), 32'd0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            model_gen(d, cyc);
            q_dir.push_back(d);
            q_lat.push_back(cyc);
            chk("busy_gen", 32'(busy), 32'd1);
            lat = 0;
            while (!move_val && lat < 8) begin
                @(posedge clk); #1;
                lat++;
            end
            chk("latency", 32'(lat), 32'(q_lat.pop_front()));
            exp_d = q_dir.pop_front();
            if (!move_val) return;
            chk("direction", 32'(direction), 32'(exp_d));
            chk("legal", 32'(m_legal(direction)), 32'd1);
            seq_obs.push_back(direction);
            hold = direction;
            stalls = 0;
            do begin
                if (stall >= 0) rdy = (stalls >= stall);
                else rdy = ($urandom_range(0, 99) < 50) || (stalls >= 20);
                move_rdy = rdy;
                if (!rdy) begin
                    @(posedge clk); #1;
                    stalls++;
                    chk("stall_val", 32'(move_val), 32'd1);
                    chk("stall_dir", 32'(direction), 32'(hold));
                    chk("stall_row", 32'(space_row), 32'(m_row));
                    chk("stall_col", 32'(space_col), 32'(m_col));
                end
            end while (!rdy);
            @(posedge clk); #1;
            move_rdy = 1'b0;
            model_apply(exp_d);
            hs++;
            chk("row", 32'(space_row), 32'(m_row));
            chk("col", 32'(space_col), 32'(m_col));
            if (i == n - 1) begin
                chk("done", 32'(done), 32'd1);
                chk("busy_end", 32'(busy), 32'd0);
                chk("val_end", 32'(move_val), 32'd0);
            end else begin
                chk("no_done", 32'(done), 32'd0);
            end
            if (hs == stop_after) return;
        end
        @(posedge clk); #1;
        chk("done_once", 32'(done), 32'd0);
        chk("handshakes", 32'(hs), 32'(n));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; num_moves = '0; seed_load = 1'b0;
        seed = '0; move_rdy = 1'b0;
        do_reset();
        chk("rst_val", 32'(move_val), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_row", 32'(space_row), 32'd2);
        chk("rst_col", 32'(space_col), 32'd2);
        chk("rst_dir", 32'(direction), 32'd0);

        // single move from the corner: must be LEFT or UP
        move_rdy = 1'b1;
        run(1, 0, 0, 1'b0, 16'h0);
        chk("first_move_lu", 32'(seq_obs[0] == 2'b00 || seq_obs[0] == 2'b10), 32'd1);

        // zero-count start
        run(0, 0, 0, 1'b0, 16'h0);

        // backpressure of 10 cycles per move; blank persists from before
        run(3, 10, 0, 1'b0, 16'h0);

        // long random-ready scramble
        run(255, -1, 0, 1'b0, 16'h0);

        // seed reproducibility
        do_reset();
        load_seed(16'h1234);
        run(20, -1, 0, 1'b0, 16'h0);
        seq_a = seq_obs;
        do_reset();
        load_seed(16'h1234);
        run(20, -1, 0, 1'b0, 16'h0);
        seq_b = seq_obs;
        chk("seed_len", 32'(seq_b.size()), 32'(seq_a.size()));
        for (int i = 0; i < seq_a.size() && i < seq_b.size(); i++)
            chk("seed_repeat", 32'(seq_b[i]), 32'(seq_a[i]));

        // zero seed behaves as the default seed
        do_reset();
        run(20, 0, 0, 1'b0, 16'h0);
        seq_def = seq_obs;
        do_reset();
        load_seed(16'h0000);
        run(20, 0, 0, 1'b0, 16'h0);
        for (int i = 0; i < seq_def.size() && i < seq_obs.size(); i++)
            chk("seed_zero", 32'(seq_obs[i]), 32'(seq_def[i]));

        // seed_load together with start uses the new seed
        run(8, 0, 0, 1'b1, 16'h5A5A);

        // reset after the third handshake of a 10-move scramble
        run(10, 0, 3, 1'b0, 16'h0);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_lfsr = SEED; m_row = 2'd2; m_col = 2'd2; m_pv = 1'b0;
        q_dir.delete(); q_lat.delete();
        chk("midrst_val", 32'(move_val), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_row", 32'(space_row), 32'd2);
        chk("midrst_col", 32'(space_col), 32'd2);
        run(5, -1, 0, 1'b0, 16'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
